// File: rtl/ddr3_frame_pkg.sv
// Shared types, word geometry and frame sizing helpers for the DDR3 frame writer.
package ddr3_frame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned PIX_PER_WORD = 16;
   localparam int unsigned WORD_BITS    = 128;
   localparam int unsigned PIXEL_BITS   = 8;

   function automatic int unsigned frame_pixels(input int unsigned width, input int unsigned height);
      return width * height;
   endfunction

   function automatic int unsigned frame_words(input int unsigned width, input int unsigned height);
      return frame_pixels(width, height) / PIX_PER_WORD;
   endfunction

endpackage

// File: rtl/ddr3_frame_writer_if.sv
// Pixel stream and single-beat DDR3 write request bundle; master is the frame writer.
interface ddr3_frame_writer_if;
   import ddr3_frame_pkg::*;

   logic                  in_valid;
   logic [PIXEL_BITS-1:0] in_pixel;
   logic                  in_ready;
   logic                  wr_en;
   logic [WORD_BITS-1:0]  write_data_input;
   logic [31:0]           sdram_address;
   logic                  write_complete;

   modport master (
      input  in_valid, in_pixel, write_complete,
      output in_ready, wr_en, write_data_input, sdram_address
   );

   modport slave (
      output in_valid, in_pixel, write_complete,
      input  in_ready, wr_en, write_data_input, sdram_address
   );

endinterface

// File: rtl/pixel_packer_16x8.sv
// Packs 16 accepted 8-bit pixels into a 128-bit word (pixel 0 in the LSBs) and offers it downstream.
module pixel_packer_16x8
   import ddr3_frame_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = 16
) (
   input  logic                  main_clk,
   input  logic                  main_reset,
   input  logic                  clear,
   input  logic                  run,
   input  logic                  in_valid,
   input  logic [PIXEL_BITS-1:0] in_pixel,
   output logic                  in_ready,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [WORD_BITS-1:0]  word_data
);

   logic [4:0]  pack_count;
   logic [31:0] pix_accepted;
   logic        accept;

   // Ready depends only on registers, so no combinational path from in_valid.
   assign in_ready   = run && (pack_count < 5'(PIX_PER_WORD)) && (pix_accepted < FRAME_PIXELS);
   assign word_valid = (pack_count == 5'(PIX_PER_WORD));
   assign accept     = in_valid && in_ready;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge main_clk or negedge main_reset) begin
      if (!main_reset) begin
         pack_count   <= '0;
         pix_accepted <= '0;
         word_data    <= '0;
      end else if (clear) begin
         pack_count   <= '0;
         pix_accepted <= '0;
      end else if (accept) begin
         word_data[{pack_count[3:0], 3'b000} +: PIXEL_BITS] <= in_pixel;
         pack_count   <= pack_count + 5'd1;
         pix_accepted <= pix_accepted + 32'd1;
      end else if (word_valid && word_ready) begin
         pack_count <= '0;
      end
   end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Streams a frame of pixels into consecutive 128-bit single-beat DDR3 writes.
// Optional DDR3_FRAME_WRITER_STALL_CNT_EN adds a stall_cycles counter output.
module ddr3_frame_writer
   import ddr3_frame_pkg::*;
#(
   parameter int unsigned IMG_WIDTH   = 720,
   parameter int unsigned IMG_HEIGHT  = 540,
   parameter int unsigned ADDR_STRIDE = 16
) (
   input  logic                       main_clk,
   input  logic                       main_reset,
   input  logic                       start,
   input  logic [31:0]                base_addr,
   ddr3_frame_writer_if.master        bus,
   output logic                       busy,
   output logic                       frame_done
`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
   ,
   output logic [31:0]                stall_cycles
`endif
);

   localparam int unsigned FRAME_PIXELS    = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
   localparam int unsigned WORDS_PER_FRAME = frame_words(IMG_WIDTH, IMG_HEIGHT);

   if ((FRAME_PIXELS % PIX_PER_WORD) != 0) begin : g_bad_frame_size
      $error("ddr3_frame_writer: IMG_WIDTH*IMG_HEIGHT must be a multiple of 16");
   end

   state_t               state_q, state_d;
   logic                 buf_valid;
   logic [WORD_BITS-1:0] buf_data;
   logic [31:0]          addr_q;
   logic [31:0]          words_written;
   logic                 start_accept;
   logic                 last_retire;
   logic                 word_valid;
   logic                 word_ready;
   logic [WORD_BITS-1:0] word_data;

   assign start_accept = (state_q == IDLE) && start;
   assign last_retire  = bus.write_complete && buf_valid && (words_written == WORDS_PER_FRAME - 1);
   assign word_ready   = (state_q == RUN) && !buf_valid;

   pixel_packer_16x8 #(
      .FRAME_PIXELS(FRAME_PIXELS)
   ) u_packer (
      .main_clk  (main_clk),
      .main_reset(main_reset),
      .clear     (start_accept),
      .run       (state_q == RUN),
      .in_valid  (bus.in_valid),
      .in_pixel  (bus.in_pixel),
      .in_ready  (bus.in_ready),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .word_data (word_data)
   );

   // NOTE: defaults first keep every path assigned, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      busy       = (state_q != IDLE);
      frame_done = (state_q == DONE);
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_retire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The buffer holds one word; while it is occupied the request lines stay frozen.
   always_ff @(posedge main_clk or negedge main_reset) begin
      if (!main_reset) begin
         state_q       <= IDLE;
         buf_valid     <= 1'b0;
         buf_data      <= '0;
         addr_q        <= '0;
         words_written <= '0;
      end else begin
         state_q <= state_d;
         if (start_accept) begin
            buf_valid     <= 1'b0;
            addr_q        <= base_addr;
            words_written <= '0;
         end else if (buf_valid) begin
            if (bus.write_complete) begin
               buf_valid     <= 1'b0;
               addr_q        <= addr_q + ADDR_STRIDE;
               words_written <= words_written + 32'd1;
            end
         end else if (word_valid && word_ready) begin
            buf_data  <= word_data;
            buf_valid <= 1'b1;
         end
      end
   end

   assign bus.wr_en            = buf_valid;
   assign bus.write_data_input = buf_data;
   assign bus.sdram_address    = addr_q;

`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
   always_ff @(posedge main_clk or negedge main_reset) begin
      if (!main_reset) begin
         stall_cycles <= '0;
      end else if (start_accept) begin
         stall_cycles <= '0;
      end else if ((state_q == RUN) && buf_valid && !bus.write_complete) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Scoreboard bench for ddr3_frame_writer on a 32x2 frame (4 words per frame).
module tb_ddr3_frame_writer;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } wr_t;

   logic        main_clk   = 1'b0;
   logic        main_reset = 1'b0;
   logic        start      = 1'b0;
   logic [31:0] base_addr  = '0;
   logic        busy;
   logic        frame_done;
`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   ddr3_frame_writer_if bus ();

   ddr3_frame_writer #(
      .IMG_WIDTH  (32),
      .IMG_HEIGHT (2),
      .ADDR_STRIDE(16)
   ) dut (
      .main_clk    (main_clk),
      .main_reset  (main_reset),
      .start       (start),
      .base_addr   (base_addr),
      .bus         (bus),
      .busy        (busy),
      .frame_done  (frame_done)
`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 main_clk = ~main_clk;

   int cyc = 0;
   always @(posedge main_clk) cyc <= cyc + 1;

   int           compared   = 0;
   int           mismatched = 0;
   wr_t          exp_q[$];
   wr_t          wr_log[$];
   int           lat        = 3;
   int           wc_cyc     = -1;
   int           fd_cyc     = -2;
   int           fd_count   = 0;
   int           bp_cycles  = 0;
   logic [31:0]  exp_addr   = '0;
   logic [127:0] acc        = '0;
   int           acc_n      = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // DDR3 interface model: compares each request against the scoreboard, holds it lat cycles, then completes.
   initial begin : ddr_model
      wr_t got;
      wr_t exp;
      bit  aborted;
      bus.write_complete = 1'b0;
      forever begin
         @(posedge main_clk); #1;
         if (main_reset && bus.wr_en) begin
            got.addr = bus.sdram_address;
            got.data = bus.write_data_input;
            wr_log.push_back(got);
            check("sb_nonempty", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               check("wr_addr", got.addr, exp.addr);
               check("wr_data", got.data, exp.data);
            end
            aborted = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(posedge main_clk); #1;
               if (!main_reset) begin
                  aborted = 1'b1;
                  break;
               end
               check("wr_en_held", bus.wr_en, 1'b1);
               check("addr_stable", bus.sdram_address, got.addr);
               check("data_stable", bus.write_data_input, got.data);
            end
            if (!aborted) begin
               bus.write_complete = 1'b1;
               @(posedge main_clk); #1;
               bus.write_complete = 1'b0;
               wc_cyc = cyc;
               if (main_reset) check("wr_en_gap", bus.wr_en, 1'b0);
            end
         end
      end
   end

   initial begin : done_monitor
      forever begin
         @(posedge main_clk); #1;
         if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: run exceeded its time limit (compared=%0d)", compared);
      $fatal(1, "watchdog expired");
   end

   task automatic send_pixel(input logic [7:0] p);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_pixel = p;
      while (!bus.in_ready && waited < 500) begin
         bp_cycles++;
         @(posedge main_clk); #1;
         waited++;
      end
      if (waited >= 500) check("pixel_accept_timeout", bus.in_ready, 1'b1);
      @(posedge main_clk); #1;
      acc[acc_n*8 +: 8] = p;
      acc_n++;
      if (acc_n == 16) begin
         exp_q.push_back('{addr: exp_addr, data: acc});
         exp_addr = exp_addr + 32'd16;
         acc_n    = 0;
      end
   endtask

   task automatic send_run(input int n, input logic [7:0] first, input bit rnd);
      for (int i = 0; i < n; i++) send_pixel(rnd ? 8'($urandom) : first + 8'(i));
      bus.in_valid = 1'b0;
   endtask

   task automatic start_frame(input logic [31:0] b);
      @(posedge main_clk); #1;
      start     = 1'b1;
      base_addr = b;
      @(posedge main_clk); #1;
      start    = 1'b0;
      exp_addr = b;
      acc_n    = 0;
      wr_log.delete();
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_frame_done(input int exp_count);
      int n = 0;
      while (fd_count < exp_count && n < 3000) begin
         @(posedge main_clk); #3;
         n++;
      end
      check("frame_done_seen", fd_count, exp_count);
      check("busy_in_done", busy, 1'b1);
      check("frame_done_timing", fd_cyc, wc_cyc);
      check("sb_drained", exp_q.size(), 0);
      @(posedge main_clk); #3;
      check("frame_done_pulse", frame_done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      repeat (2) @(posedge main_clk);
      #3;
      check("frame_done_once", fd_count, exp_count);
   endtask

   initial begin : main
      bus.in_valid = 1'b0;
      bus.in_pixel = '0;
      repeat (3) @(posedge main_clk);
      #1;
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_addr", bus.sdram_address, 32'h0);
      check("rst_data", bus.write_data_input, 128'h0);
`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
      check("rst_stall", stall_cycles, 32'h0);
`endif
      main_reset = 1'b1;

      // Frame A: counting pixels, 3-cycle completion latency, then extra pixels must be refused.
      lat = 3;
      start_frame(32'h0000_1000);
      send_run(64, 8'h00, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(posedge main_clk); #1;
         check("saturated_in_ready", bus.in_ready, 1'b0);
      end
      bus.in_valid = 1'b0;
      wait_frame_done(1);
      check("a_writes", wr_log.size(), 4);
      check("a_w0_addr", wr_log[0].addr, 32'h0000_1000);
      check("a_w0_data", wr_log[0].data, 128'h0F0E0D0C0B0A09080706050403020100);
      check("a_w3_addr", wr_log[3].addr, 32'h0000_1030);

      // Frame B: random pixels, zero-latency completion, base 0.
      lat = 0;
      start_frame(32'h0000_0000);
      send_run(64, 8'h00, 1'b1);
      wait_frame_done(2);
      check("b_writes", wr_log.size(), 4);
      check("b_w1_addr", wr_log[1].addr, 32'h0000_0010);
      check("b_w2_addr", wr_log[2].addr, 32'h0000_0020);
      check("b_w3_addr", wr_log[3].addr, 32'h0000_0030);

      // Frame C: long completion latency forces backpressure on the pixel stream.
      lat       = 40;
      bp_cycles = 0;
      start_frame(32'h2000_0000);
      send_run(64, 8'h80, 1'b0);
      check("backpressure_seen", 128'(bp_cycles >= 40), 128'd1);
      wait_frame_done(3);
      check("c_writes", wr_log.size(), 4);

      // Frame D: reset while word 0 is pending and a partial word is packed.
      start_frame(32'h0000_3000);
      send_run(20, 8'h10, 1'b0);
      check("d_wr_pending", bus.wr_en, 1'b1);
      #3;
      main_reset = 1'b0;
      #1;
      check("async_wr_en", bus.wr_en, 1'b0);
      check("async_busy", busy, 1'b0);
      check("async_in_ready", bus.in_ready, 1'b0);
      check("async_addr", bus.sdram_address, 32'h0);
      check("async_data", bus.write_data_input, 128'h0);
      repeat (3) @(posedge main_clk);
      #1;
      main_reset = 1'b1;
      check("d_sb_empty", exp_q.size(), 0);
      lat = 2;
      start_frame(32'h0000_4000);
      send_run(64, 8'h40, 1'b0);
      wait_frame_done(4);
      check("d_writes", wr_log.size(), 4);
      check("d_w0_addr", wr_log[0].addr, 32'h0000_4000);
      check("d_w0_data", wr_log[0].data, 128'h4F4E4D4C4B4A49484746454443424140);

      // Frame E: address wrap and a start pulse while busy that must be ignored.
      lat = 5;
      start_frame(32'hFFFF_FFE0);
      send_run(32, 8'hC0, 1'b0);
      start     = 1'b1;
      base_addr = 32'h5555_0000;
      @(posedge main_clk); #1;
      start = 1'b0;
      check("busy_ignores_start", busy, 1'b1);
      send_run(32, 8'hE0, 1'b0);
      wait_frame_done(5);
      check("e_writes", wr_log.size(), 4);
      check("e_w0_addr", wr_log[0].addr, 32'hFFFF_FFE0);
      check("e_w1_addr", wr_log[1].addr, 32'hFFFF_FFF0);
      check("e_w2_addr", wr_log[2].addr, 32'h0000_0000);
      check("e_w3_addr", wr_log[3].addr, 32'h0000_0010);
`ifdef DDR3_FRAME_WRITER_STALL_CNT_EN
      check("stall_cycles", stall_cycles, 32'd20);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
